scan_led_mux: RTL and testbench
===============================

SCAN_LED_MUX -- requirements
Module: scan_led_mux

Interface
REQ-001 The block SHALL have parameter DIGITS, default 6, giving the number of multiplexed digits (legal range 2..8).
REQ-002 The block SHALL have parameter DIV, default 25000, giving clk cycles per digit slot (minimum 4).
REQ-003 The block SHALL have parameter GAP, default 2, giving the all-off cycles at the start of each slot (legal range 0..DIV-2).
REQ-004 The block SHALL have port clk, input, 1 bit: the board clock, the single clock domain.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: display enable.
REQ-007 The block SHALL have port load, input, 1 bit: one-cycle strobe that captures datain, dp_in and blank_in.
REQ-008 The block SHALL have port datain, input, 4*DIGITS bits: hex nibbles, with nibble i driving digit i (digit 0 is least significant).
REQ-009 The block SHALL have port dp_in, input, DIGITS bits: decimal point per digit, active-high.
REQ-010 The block SHALL have port blank_in, input, DIGITS bits: forces a digit dark, active-high.
REQ-011 The block SHALL have port seg, output, 8 bits: active-low segment bus, bits 7..1 = a..g and bit 0 = dp.
REQ-012 The block SHALL have port scan, output, DIGITS bits: active-low digit select, with bit i selecting digit i.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when digit DIGITS-1's slot ends.

Function
REQ-014 A divider counting 0..DIV-1 SHALL assert an internal tick on the cycle it holds DIV-1 and SHALL then wrap to 0.
REQ-015 On each tick, the digit index SHALL advance by one, wrapping from DIGITS-1 to 0.
REQ-016 scan SHALL be all ones while the divider is below GAP, and SHALL otherwise be all ones with bit[index] at 0.
REQ-017 seg SHALL be 8'hFF whenever scan is all ones.
REQ-018 seg and scan SHALL be registered and SHALL change on the same clk edge.
REQ-019 On load, a shadow register SHALL capture datain, dp_in and blank_in on the next edge (one-cycle latency).
REQ-020 The display register SHALL copy the shadow only on the tick where the index wraps from DIGITS-1 to 0, so no frame ever tears.
REQ-021 When load coincides with that wrap tick, the display register SHALL take the old shadow, and the new data SHALL appear one frame later.
REQ-022 Nibble decode SHALL be 0..9 and A..F, with seg 0 = 8'b00000011, 1 = 8'b10011111, 8 = 8'b00000001 and F = 8'b01110001.
REQ-023 dp_in[i] high SHALL clear seg[0] while digit i is lit.
REQ-024 blank_in[i] high SHALL make seg 8'hFF during digit i's slot while scan still selects digit i, so brightness stays uniform.
REQ-025 While en is low, the divider and index SHALL be held at 0, scan SHALL be all ones, seg SHALL be 8'hFF, frame_done SHALL be 0, and load SHALL still operate.
REQ-026 When en rises, the first lit slot SHALL be digit 0, lit GAP cycles after the rise.
REQ-027 frame_done SHALL be high exactly on the wrap tick.

Reset
REQ-028 While rst_n is low, the divider, index and frame_done SHALL be 0, scan SHALL be all ones, seg SHALL be 8'hFF, and the shadow and display registers SHALL be 0.
REQ-029 Reset asserted mid-slot SHALL darken the outputs immediately, without waiting for a clock edge.
REQ-030 After rst_n releases, operation SHALL restart as in REQ-026.

Configuration
REQ-031 With macro SCAN_LED_LZS_EN defined, digit i (i>0) SHALL be shown dark, with seg[7:1] all 1, when nibble i and all higher nibbles are zero.
REQ-032 Under SCAN_LED_LZS_EN, digit 0 SHALL never be suppressed and the dp SHALL still follow dp_in.
REQ-033 With SCAN_LED_LZS_EN undefined, no suppression logic SHALL be present.

Structure
REQ-034 Package scan_led_pkg SHALL hold the 16 segment-pattern constants, SEG_OFF = 8'hFF, and the nibble typedef.
REQ-035 Sub-module seg7_decode SHALL be purely combinational, mapping a nibble, dp and blank to the 8-bit seg pattern.
REQ-036 The scan counter, divider and registers SHALL stay in scan_led_mux.

Verification
REQ-037 With DIGITS=4, DIV=8, GAP=2, en=1 and datain=16'h1234 loaded, the bench SHALL see scan cycle 1110, 1101, 1011, 0111 (each 6 cycles lit, 2 dark) with seg 4,3,2,1 patterns, and frame_done every 32 cycles.
REQ-038 With a second load of 16'hABCD mid-frame, the bench SHALL see the remaining digits keep 1234 and ABCD appear from digit 0 of the next frame.
REQ-039 With load coincident with the wrap tick, the bench SHALL see the new value displayed one frame later.
REQ-040 With SCAN_LED_LZS_EN defined and datain=16'h0050 loaded, the bench SHALL see digits 3 and 2 dark, digit 1 show 5, and digit 0 show 0.
REQ-041 With dp_in=4'b0100 and blank_in=4'b0001, the bench SHALL see seg[0]=0 only in digit 2's slot and seg=8'hFF in digit 0's slot.
REQ-042 With rst_n pulsed low mid-slot and en toggled, the bench SHALL see scan all ones and seg 8'hFF asynchronously, and a restart at digit 0 after GAP cycles.

Source files
------------

// File: rtl/scan_led_pkg.sv
// Shared types and active-low seven-segment patterns for the scanned LED display.
// Bit layout of every pattern: [7:1] = segments a..g, [0] = decimal point.
package scan_led_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Decimal point bit is left high (off); the decoder overrides bit 0.
  localparam logic [7:0] SEG_0 = 8'b0000_0011;
  localparam logic [7:0] SEG_1 = 8'b1001_1111;
  localparam logic [7:0] SEG_2 = 8'b0010_0101;
  localparam logic [7:0] SEG_3 = 8'b0000_1101;
  localparam logic [7:0] SEG_4 = 8'b1001_1001;
  localparam logic [7:0] SEG_5 = 8'b0100_1001;
  localparam logic [7:0] SEG_6 = 8'b0100_0001;
  localparam logic [7:0] SEG_7 = 8'b0001_1111;
  localparam logic [7:0] SEG_8 = 8'b0000_0001;
  localparam logic [7:0] SEG_9 = 8'b0000_1001;
  localparam logic [7:0] SEG_A = 8'b0001_0001;
  localparam logic [7:0] SEG_B = 8'b1100_0001;
  localparam logic [7:0] SEG_C = 8'b0110_0011;
  localparam logic [7:0] SEG_D = 8'b1000_0101;
  localparam logic [7:0] SEG_E = 8'b0110_0001;
  localparam logic [7:0] SEG_F = 8'b0111_0001;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-seven-segment decoder with decimal point and blanking.
module seg7_decode import scan_led_pkg::*; (
  input  nibble_t    nibble_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  logic [7:0] pattern;

  // Look up the glyph, then apply dp (active-high in, active-low out) and blanking.
  always_comb begin
    pattern = SEG_OFF;
    unique case (nibble_i)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = SEG_A;
      4'hB: pattern = SEG_B;
      4'hC: pattern = SEG_C;
      4'hD: pattern = SEG_D;
      4'hE: pattern = SEG_E;
      4'hF: pattern = SEG_F;
    endcase
    seg_o = blank_i ? SEG_OFF : {pattern[7:1], ~dp_i};
  end

endmodule

// File: rtl/scan_led_mux.sv
// Time-multiplexed driver for a common-anode hex LED display.
// Each digit slot lasts DIV clocks and starts with GAP dark clocks to avoid ghosting.
// New data is staged in a shadow register and moved to the display only at frame
// wrap, so a frame never mixes old and new digits.
// Optional: define SCAN_LED_LZS_EN to enable leading-zero suppression.
module scan_led_mux import scan_led_pkg::*; #(
  parameter int unsigned DIGITS = 6,
  parameter int unsigned DIV    = 25000,
  parameter int unsigned GAP    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   datain,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     scan,
  output logic                  frame_done
);

  localparam int unsigned DivW = $clog2(DIV);
  localparam int unsigned IdxW = $clog2(DIGITS);
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
  localparam logic [DivW-1:0] GapCnt  = DivW'(GAP);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

  logic [DivW-1:0]       div_q, div_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  tick, wrap;
  logic [4*DIGITS-1:0]   sh_data_q, disp_data_q, disp_data_d;
  logic [DIGITS-1:0]     sh_dp_q, disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]     sh_blank_q, disp_blank_q, disp_blank_d;
  logic                  lit_d;
  logic [DIGITS-1:0]     scan_q, scan_d;
  logic [7:0]            seg_q, seg_d, dec_seg;
  nibble_t               cur_nibble;
  logic                  cur_dp, cur_blank;

  // Divider, digit index and display-register next state.
  always_comb begin
    tick  = en && (div_q == DivLast);
    wrap  = tick && (idx_q == IdxLast);
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (!en) begin
      div_d = '0;
      idx_d = '0;
    end else if (tick) begin
      div_d = '0;
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
    disp_data_d  = wrap ? sh_data_q  : disp_data_q;
    disp_dp_d    = wrap ? sh_dp_q    : disp_dp_q;
    disp_blank_d = wrap ? sh_blank_q : disp_blank_q;
  end

  // Outputs are computed from next state so the registered bus lines up with div/idx.
  always_comb begin
    lit_d      = en && (div_d >= GapCnt);
    cur_nibble = disp_data_d[{idx_d, 2'b00} +: 4];
    cur_dp     = disp_dp_d[idx_d];
    cur_blank  = disp_blank_d[idx_d];
  end

  seg7_decode u_decode (
    .nibble_i (cur_nibble),
    .dp_i     (cur_dp),
    .blank_i  (cur_blank),
    .seg_o    (dec_seg)
  );

`ifdef SCAN_LED_LZS_EN
  logic [DIGITS-1:0] zero_from;
  logic              suppress;

  // zero_from[i]: nibble i and every higher nibble are zero.
  always_comb begin
    zero_from = '0;
    for (int i = 0; i < DIGITS; i++) begin
      zero_from[i] = ((disp_data_d >> (4 * i)) == '0);
    end
    suppress = (idx_d != '0) && zero_from[idx_d];
  end

  // Scan and segment next values; suppressed digits keep their dp.
  always_comb begin
    scan_d = lit_d ? ~(DIGITS'(1) << idx_d) : '1;
    seg_d  = SEG_OFF;
    if (lit_d) begin
      seg_d = dec_seg;
      if (suppress) seg_d[7:1] = '1;
    end
  end
`else
  // Scan and segment next values.
  always_comb begin
    scan_d = lit_d ? ~(DIGITS'(1) << idx_d) : '1;
    seg_d  = lit_d ? dec_seg : SEG_OFF;
  end
`endif

  // State and registered outputs; reset darkens the display without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      idx_q        <= '0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      scan_q       <= '1;
      seg_q        <= SEG_OFF;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      scan_q       <= scan_d;
      seg_q        <= seg_d;
      if (load) begin
        sh_data_q  <= datain;
        sh_dp_q    <= dp_in;
        sh_blank_q <= blank_in;
      end
    end
  end

  assign seg        = seg_q;
  assign scan       = scan_q;
  assign frame_done = wrap;

endmodule

// File: tb/tb_scan_led_mux.sv
// Self-checking bench for scan_led_mux (DIGITS=4, DIV=8, GAP=2).
// Reference model: one frame-position counter plus shadow/display copies; honours
// SCAN_LED_LZS_EN when defined.
module tb_scan_led_mux;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DIV    = 8;
  localparam int unsigned GAP    = 2;
  localparam int          FRAME  = DIGITS * DIV;

  logic        clk = 1'b0;
  logic        rst_n, en, load;
  logic [15:0] datain;
  logic [3:0]  dp_in, blank_in, scan;
  logic [7:0]  seg;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  scan_led_mux #(.DIGITS(DIGITS), .DIV(DIV), .GAP(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .datain     (datain),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .seg        (seg),
    .scan       (scan),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_cnt;     // clocks since the frame started (0..FRAME-1)
  logic        m_en;      // en seen at the last edge
  logic [15:0] m_sh_data, m_disp_data;
  logic [3:0]  m_sh_dp, m_sh_bl, m_disp_dp, m_disp_bl;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_en <= 1'b0;
      m_sh_data <= '0; m_sh_dp <= '0; m_sh_bl <= '0;
      m_disp_data <= '0; m_disp_dp <= '0; m_disp_bl <= '0;
    end else begin
      m_en <= en;
      if (load) begin
        m_sh_data <= datain; m_sh_dp <= dp_in; m_sh_bl <= blank_in;
      end
      if (!en) m_cnt <= 0;
      else begin
        if (m_cnt == FRAME - 1) begin
          m_disp_data <= m_sh_data; m_disp_dp <= m_sh_dp; m_disp_bl <= m_sh_bl;
        end
        m_cnt <= (m_cnt + 1) % FRAME;
      end
    end
  end

  function automatic logic [7:0] ref_pattern(input logic [3:0] n);
    case (n)
      4'h0: return 8'b00000011;  4'h1: return 8'b10011111;
      4'h2: return 8'b00100101;  4'h3: return 8'b00001101;
      4'h4: return 8'b10011001;  4'h5: return 8'b01001001;
      4'h6: return 8'b01000001;  4'h7: return 8'b00011111;
      4'h8: return 8'b00000001;  4'h9: return 8'b00001001;
      4'hA: return 8'b00010001;  4'hB: return 8'b11000001;
      4'hC: return 8'b01100011;  4'hD: return 8'b10000101;
      4'hE: return 8'b01100001;  default: return 8'b01110001;
    endcase
  endfunction

  function automatic bit m_lit();
    return m_en && ((m_cnt % DIV) >= GAP);
  endfunction

  function automatic logic [3:0] exp_scan();
    if (!m_lit()) return 4'hF;
    return ~(4'b0001 << (m_cnt / DIV));
  endfunction

  function automatic logic [7:0] exp_seg();
    int          d;
    logic [7:0]  s;
    logic [15:0] above;
    if (!m_lit()) return 8'hFF;
    d = m_cnt / DIV;
    if (m_disp_bl[d]) return 8'hFF;
    above = m_disp_data >> (4 * d);
    s = ref_pattern(above[3:0]);
    s[0] = ~m_disp_dp[d];
`ifdef SCAN_LED_LZS_EN
    if (d > 0 && above == 16'h0) s[7:1] = 7'h7F;
`endif
    return s;
  endfunction

  function automatic logic exp_done();
    return en && (m_cnt == FRAME - 1);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0; datain = '0; dp_in = '0; blank_in = '0;
    repeat (3) @(negedge clk);
    checks += 3;
    if (scan !== 4'hF) begin errors++; $display("FAIL reset_scan got %b want 1111", scan); end
    if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h want ff", seg); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", frame_done); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks += 2;
    if (scan !== 4'hF) begin errors++; $display("FAIL idle_scan got %b want 1111", scan); end
    if (seg !== 8'hFF) begin errors++; $display("FAIL idle_seg got %h want ff", seg); end
  endtask

  task automatic test_frame();
    int pulses, last_pulse;
    pulses = 0; last_pulse = -1;
    load = 1'b1; datain = 16'h1234; dp_in = '0; blank_in = '0;
    @(negedge clk);
    load = 1'b0; en = 1'b1;
    for (int k = 1; k <= 3 * FRAME; k++) begin
      @(negedge clk);
      checks += 3;
      if (scan !== exp_scan()) begin errors++; $display("FAIL frame_scan k=%0d got %b want %b", k, scan, exp_scan()); end
      if (seg !== exp_seg()) begin errors++; $display("FAIL frame_seg k=%0d got %b want %b", k, seg, exp_seg()); end
      if (frame_done !== exp_done()) begin errors++; $display("FAIL frame_done k=%0d got %b want %b", k, frame_done, exp_done()); end
      if (frame_done === 1'b1) begin
        if (last_pulse >= 0) begin
          checks++;
          if (k - last_pulse != FRAME) begin errors++; $display("FAIL done_period got %0d want %0d", k - last_pulse, FRAME); end
        end
        pulses++; last_pulse = k;
      end
      if (k == GAP - 1) begin
        checks++;
        if (scan !== 4'hF) begin errors++; $display("FAIL first_gap_scan got %b want 1111", scan); end
      end
      if (k == GAP) begin
        checks++;
        if (scan !== 4'b1110) begin errors++; $display("FAIL first_lit_scan got %b want 1110", scan); end
      end
      if (k == FRAME + GAP) begin
        checks++;
        if (seg !== 8'b10011001) begin errors++; $display("FAIL digit0_is_4 got %b want 10011001", seg); end
      end
      if (k == FRAME + 3 * DIV + GAP) begin
        checks += 2;
        if (scan !== 4'b0111) begin errors++; $display("FAIL digit3_scan got %b want 0111", scan); end
        if (seg !== 8'b10011111) begin errors++; $display("FAIL digit3_is_1 got %b want 10011111", seg); end
      end
    end
    checks++;
    if (pulses != 3) begin errors++; $display("FAIL done_count got %0d want 3", pulses); end
  endtask

  task automatic test_midframe_load();
    bit seen2, seen0;
    seen2 = 1'b0; seen0 = 1'b0;
    for (int i = 0; i < 2 * FRAME && m_cnt != DIV + 3; i++) @(negedge clk);
    checks++;
    if (m_cnt != DIV + 3) begin errors++; $display("FAIL mid_wait got %0d want %0d", m_cnt, DIV + 3); end
    load = 1'b1; datain = 16'hABCD;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      checks += 3;
      if (scan !== exp_scan()) begin errors++; $display("FAIL mid_scan got %b want %b", scan, exp_scan()); end
      if (seg !== exp_seg()) begin errors++; $display("FAIL mid_seg got %b want %b", seg, exp_seg()); end
      if (frame_done !== exp_done()) begin errors++; $display("FAIL mid_done got %b want %b", frame_done, exp_done()); end
      if (!seen2 && m_cnt == 2 * DIV + GAP) begin
        seen2 = 1'b1; checks++;
        if (seg !== 8'b00100101) begin errors++; $display("FAIL mid_keeps_old got %b want 00100101", seg); end
      end
      if (!seen0 && m_cnt == GAP) begin
        seen0 = 1'b1; checks++;
        if (seg !== 8'b10000101) begin errors++; $display("FAIL mid_new_d got %b want 10000101", seg); end
      end
    end
  endtask

  task automatic test_load_on_wrap();
    logic [15:0] old_v, new_v;
    int          seen;
    seen = 0;
    for (int i = 0; i < 2 * FRAME && m_cnt != FRAME - 1; i++) @(negedge clk);
    checks++;
    if (m_cnt != FRAME - 1) begin errors++; $display("FAIL wrap_wait got %0d want %0d", m_cnt, FRAME - 1); end
    old_v = m_sh_data;
    new_v = 16'($urandom);
    if (new_v[3:0] == old_v[3:0]) new_v[3:0] = old_v[3:0] + 4'h1;
    load = 1'b1; datain = new_v; dp_in = '0; blank_in = '0;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 2 * FRAME + 4; k++) begin
      checks += 3;
      if (scan !== exp_scan()) begin errors++; $display("FAIL wrap_scan got %b want %b", scan, exp_scan()); end
      if (seg !== exp_seg()) begin errors++; $display("FAIL wrap_seg got %b want %b", seg, exp_seg()); end
      if (frame_done !== exp_done()) begin errors++; $display("FAIL wrap_done got %b want %b", frame_done, exp_done()); end
      if (m_cnt == GAP && seen < 2) begin
        checks++;
        if (seen == 0 && seg[7:1] !== ref_pattern(old_v[3:0]) >> 1) begin
          errors++; $display("FAIL wrap_old_frame got %b want %b", seg[7:1], ref_pattern(old_v[3:0]) >> 1);
        end
        if (seen == 1 && seg[7:1] !== ref_pattern(new_v[3:0]) >> 1) begin
          errors++; $display("FAIL wrap_new_frame got %b want %b", seg[7:1], ref_pattern(new_v[3:0]) >> 1);
        end
        seen++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_dp_blank();
    int dp_other, dp_in2, blank_bad;
    dp_other = 0; dp_in2 = 0; blank_bad = 0;
    load = 1'b1; datain = 16'($urandom); dp_in = 4'b0100; blank_in = 4'b0001;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      @(negedge clk);
      checks += 2;
      if (scan !== exp_scan()) begin errors++; $display("FAIL dpb_scan got %b want %b", scan, exp_scan()); end
      if (seg !== exp_seg()) begin errors++; $display("FAIL dpb_seg got %b want %b", seg, exp_seg()); end
      if (k >= FRAME + 2) begin
        if (seg[0] === 1'b0 && scan !== 4'b1011) dp_other++;
        if (seg[0] === 1'b0 && scan === 4'b1011) dp_in2++;
        if (scan === 4'b1110 && seg !== 8'hFF) blank_bad++;
      end
    end
    checks += 3;
    if (dp_other != 0) begin errors++; $display("FAIL dp_wrong_digit got %0d want 0", dp_other); end
    if (dp_in2 != 2 * (DIV - GAP)) begin errors++; $display("FAIL dp_digit2 got %0d want %0d", dp_in2, 2 * (DIV - GAP)); end
    if (blank_bad != 0) begin errors++; $display("FAIL blank_digit0 got %0d want 0", blank_bad); end
  endtask

  task automatic test_lzs();
    logic [7:0] want3;
`ifdef SCAN_LED_LZS_EN
    want3 = 8'hFF;
`else
    want3 = 8'b00000011;
`endif
    load = 1'b1; datain = 16'h0050; dp_in = '0; blank_in = '0;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      @(negedge clk);
      checks += 2;
      if (scan !== exp_scan()) begin errors++; $display("FAIL lzs_scan got %b want %b", scan, exp_scan()); end
      if (seg !== exp_seg()) begin errors++; $display("FAIL lzs_seg got %b want %b", seg, exp_seg()); end
      if (k >= 2 * FRAME) begin
        checks++;
        if (scan === 4'b0111 && seg !== want3) begin errors++; $display("FAIL lzs_d3 got %b want %b", seg, want3); end
        else if (scan === 4'b1101 && seg !== 8'b01001001) begin errors++; $display("FAIL lzs_d1 got %b want 01001001", seg); end
        else if (scan === 4'b1110 && seg !== 8'b00000011) begin errors++; $display("FAIL lzs_d0 got %b want 00000011", seg); end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      checks += 3;
      if (scan !== exp_scan()) begin errors++; $display("FAIL rnd_scan k=%0d got %b want %b", k, scan, exp_scan()); end
      if (seg !== exp_seg()) begin errors++; $display("FAIL rnd_seg k=%0d got %b want %b", k, seg, exp_seg()); end
      if (frame_done !== exp_done()) begin errors++; $display("FAIL rnd_done k=%0d got %b want %b", k, frame_done, exp_done()); end
      load     = ($urandom_range(0, 5) == 0);
      datain   = 16'($urandom);
      dp_in    = 4'($urandom);
      blank_in = 4'($urandom);
      if ($urandom_range(0, 59) == 0) en = ~en;
    end
    load = 1'b0; en = 1'b1;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2 * FRAME && scan === 4'hF; i++) @(negedge clk);
    checks++;
    if (scan === 4'hF) begin errors++; $display("FAIL areset_wait got %b want lit", scan); end
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (scan !== 4'hF) begin errors++; $display("FAIL areset_scan got %b want 1111", scan); end
    if (seg !== 8'hFF) begin errors++; $display("FAIL areset_seg got %h want ff", seg); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL areset_done got %b want 0", frame_done); end
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    for (int k = 1; k <= FRAME + 4; k++) begin
      @(negedge clk);
      checks += 2;
      if (scan !== exp_scan()) begin errors++; $display("FAIL restart_scan k=%0d got %b want %b", k, scan, exp_scan()); end
      if (seg !== exp_seg()) begin errors++; $display("FAIL restart_seg k=%0d got %b want %b", k, seg, exp_seg()); end
      if (k == GAP - 1) begin
        checks++;
        if (scan !== 4'hF) begin errors++; $display("FAIL restart_gap got %b want 1111", scan); end
      end
      if (k == GAP) begin
        checks += 2;
        if (scan !== 4'b1110) begin errors++; $display("FAIL restart_digit0 got %b want 1110", scan); end
        if (seg !== 8'b00000011) begin errors++; $display("FAIL restart_cleared got %b want 00000011", seg); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_midframe_load();
    test_load_on_wrap();
    test_dp_blank();
    test_lzs();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
